// File: rtl/luhn_gen.sv
// luhn_gen: loads a 15-digit BCD payload, computes the Luhn check digit and
// streams check digit first, then the payload right-to-left, one digit per
// consumer advance pulse.
// Optional feature macro: LUHN_GEN_CORRUPT_EN adds input 'corrupt', which bumps
// the check digit by one (mod 10) when sampled high in CALC.
module luhn_gen (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       run,
  output logic [3:0] dout,
  output logic       dout_active,
  input  logic       dout_req,
  output logic [3:0] check_digit,
  output logic       check_valid,
  output logic       err
`ifdef LUHN_GEN_CORRUPT_EN
  ,
  input  logic       corrupt
`endif
);

  typedef enum logic [1:0] {LOAD, CALC, READY, SEND} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [7:0] sum;
  logic [3:0] oidx;
  logic [3:0] payload [15];

  logic       accept, reject;
  logic [4:0] dbl, addend;
  logic [3:0] sum_mod, cd_calc, cd_final;

  // Accept/reject decode and Luhn digit weighting. Even indices are doubled
  // because index 14 sits next to the check digit.
  always_comb begin
    accept  = (state == LOAD) && din_valid && (din <= 4'd9);
    reject  = (state == LOAD) && din_valid && (din > 4'd9);
    dbl     = {din, 1'b0};
    addend  = cnt[0] ? {1'b0, din} : ((dbl > 5'd9) ? dbl - 5'd9 : dbl);
    sum_mod = 4'(sum % 8'd10);
    cd_calc = (sum_mod == 4'd0) ? 4'd0 : 4'd10 - sum_mod;
`ifdef LUHN_GEN_CORRUPT_EN
    cd_final = corrupt ? ((cd_calc == 4'd9) ? 4'd0 : cd_calc + 4'd1) : cd_calc;
`else
    cd_final = cd_calc;
`endif
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  // Next-state logic; run is only honoured once the check digit exists
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && cnt == 4'd14) state_nxt = CALC;
      CALC:    state_nxt = READY;
      READY:   if (run) state_nxt = SEND;
      SEND:    if (!run) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Load counter, running sum, check digit, output index and error pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= 4'd0;
      sum         <= 8'd0;
      oidx        <= 4'd15;
      check_digit <= 4'd0;
      err         <= 1'b0;
    end else begin
      err <= reject;
      case (state)
        LOAD: if (accept) begin
          cnt <= cnt + 4'd1;
          sum <= sum + {3'b0, addend};
        end
        CALC:  check_digit <= cd_final;
        READY: oidx <= 4'd15;
        SEND: begin
          if (!run) begin
            cnt  <= 4'd0;
            sum  <= 8'd0;
            oidx <= 4'd15;
          end else if (dout_req && oidx != 4'd0) begin
            oidx <= oidx - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Payload storage; only digits written in the current load are ever read
  always_ff @(posedge clock) begin
    if (accept) payload[cnt] <= din;
  end

  // Status and stream outputs; index 15 selects the check digit
  always_comb begin
    din_ready   = (state == LOAD);
    check_valid = (state == READY) || (state == SEND);
    dout_active = (state == SEND);
    dout        = 4'd0;
    if (state == SEND) dout = (oidx == 4'd15) ? check_digit : payload[oidx];
  end

endmodule

// File: tb/tb_luhn_gen.sv
// Scoreboarded bench for luhn_gen: stimulus pushes expected stream digits and
// check digits into queues; a negedge monitor pops and compares them.
module tb_luhn_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din = 4'd0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       run = 1'b0;
  logic [3:0] dout;
  logic       dout_active;
  logic       dout_req = 1'b0;
  logic [3:0] check_digit;
  logic       check_valid;
  logic       err;

  luhn_gen dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .run(run), .dout(dout), .dout_active(dout_active),
    .dout_req(dout_req), .check_digit(check_digit), .check_valid(check_valid),
    .err(err)
  );

  always #5 clock = ~clock;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] exp_q [$];
  logic [3:0] cd_q [$];
  logic [3:0] pay [15];
  logic       prev_cv = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the check digit is whichever d makes the full 16-digit number
  // pass the Luhn test (every second digit from the right doubled, digit-summed).
  function automatic logic [3:0] ref_cd();
    int tot, v;
    for (int d = 0; d < 10; d++) begin
      tot = 0;
      for (int i = 0; i < 16; i++) begin
        v = (i == 0) ? d : int'(pay[15 - i]);
        if (i % 2 == 1) begin
          v = v * 2;
          v = v / 10 + v % 10;
        end
        tot += v;
      end
      if (tot % 10 == 0) return 4'(d);
    end
    return 4'hf;
  endfunction

  // Monitor: one stream expectation per active cycle, one check digit per
  // rising check_valid
  always @(negedge clock) begin
    if (dout_active === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_stream", 1, 0);
      else chk("dout", dout, exp_q.pop_front());
    end
    if (check_valid === 1'b1 && !prev_cv) begin
      if (cd_q.size() == 0) chk("unexpected_check_valid", 1, 0);
      else chk("check_digit", check_digit, cd_q.pop_front());
    end
    prev_cv = (check_valid === 1'b1);
  end

  // Load pay[] with optional rejected digit before index bad_at; ends in READY
  task automatic load(input int bad_at);
    for (int i = 0; i < 15; i++) begin
      if (i == bad_at) begin
        din = 4'($urandom_range(10, 15)); din_valid = 1'b1;
        @(posedge clock); #1; din_valid = 1'b0;
        chk("err_pulse", err, 1);
        chk("din_ready_after_err", din_ready, 1);
      end
      if ($urandom_range(0, 3) == 0) begin
        din = 4'($urandom); din_valid = 1'b0;
        dout_req = 1'($urandom);
        @(posedge clock); #1;
        chk("err_idle", err, 0);
      end
      din = pay[i]; din_valid = 1'b1; dout_req = 1'($urandom);
      @(posedge clock); #1; din_valid = 1'b0; dout_req = 1'b0;
      if (i == bad_at) chk("err_one_cycle", err, 0);
      if (i < 14) chk("din_ready_load", din_ready, 1);
    end
    chk("din_ready_calc", din_ready, 0);
    cd_q.push_back(ref_cd());
    @(posedge clock); #1;
  endtask

  // Stream from READY; reset_after>=0 asserts reset after that many advances
  task automatic stream(input int reset_after, input int extra);
    int  n, ex, guard;
    bit  req;
    n = 0; ex = 0; guard = 0;
    run = 1'b1;
    exp_q.push_back(ref_cd());
    @(posedge clock); #1;
    while (guard < 300) begin
      guard++;
      if (reset_after >= 0 && n == reset_after) break;
      if (n == 15 && ex >= extra) break;
      req = (n == 15) ? 1'b1 : 1'($urandom_range(0, 1));
      dout_req = req;
      if (req && n < 15) n++;
      else if (req) ex++;
      exp_q.push_back((n == 0) ? ref_cd() : pay[15 - n]);
      @(posedge clock); #1; dout_req = 1'b0;
    end
    if (guard >= 300) chk("stream_guard", guard, 0);
    if (reset_after >= 0) begin
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0; run = 1'b0;
    end else begin
      run = 1'b0;
      @(posedge clock); #1;
    end
    chk("dout_active_after", dout_active, 0);
    chk("dout_zero_after", dout, 0);
    chk("din_ready_after", din_ready, 1);
    chk("check_valid_after", check_valid, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_dout_active", dout_active, 0);
    chk("rst_dout", dout, 0);
    chk("rst_din_ready", din_ready, 1);
    chk("rst_check_valid", check_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_check_digit", check_digit, 0);

    // 4 followed by fourteen zeros
    foreach (pay[i]) pay[i] = 4'd0;
    pay[0] = 4'd4;
    load(-1);
    stream(-1, 0);

    // fifteen nines, maximum sum, extra advances hold payload[0]
    foreach (pay[i]) pay[i] = 4'd9;
    load(-1);
    stream(-1, 2);

    // rejected digit at cnt=3, then reset mid-stream after 6 advances
    foreach (pay[i]) pay[i] = 4'($urandom_range(0, 9));
    load(3);
    stream(6, 0);

    // all zeros after the mid-stream reset
    foreach (pay[i]) pay[i] = 4'd0;
    load(-1);
    stream(-1, 0);

    // run held high through the whole load must not start early
    foreach (pay[i]) pay[i] = 4'($urandom_range(0, 9));
    run = 1'b1;
    load(-1);
    stream(-1, 3);

    // randomized payloads
    for (int t = 0; t < 20; t++) begin
      foreach (pay[i]) pay[i] = 4'($urandom_range(0, 9));
      load(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 14)) : -1);
      stream(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1,
             int'($urandom_range(0, 3)));
    end

    chk("cd_queue_drained", cd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/luhn_gen.md
LUHN_GEN -- requirements
Module: luhn_gen

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high; sampled on rising edge of clock.
REQ-003 SHALL have port: din  input  4  payload digit, BCD, entered leftmost first.
REQ-004 SHALL have port: din_valid  input  1  din offered this cycle.
REQ-005 SHALL have port: din_ready  output  1  high in LOAD only.
REQ-006 SHALL have port: run  input  1  level; request to stream the 16-digit number.
REQ-007 SHALL have port: dout  output  4  digit presented to the consumer, check digit first, then payload right-to-left.
REQ-008 SHALL have port: dout_active  output  1  stream enable to the consumer (drives its luhn_on).
REQ-009 SHALL have port: dout_req  input  1  one-cycle advance pulse from the consumer.
REQ-010 SHALL have port: check_digit  output  4  computed check digit.
REQ-011 SHALL have port: check_valid  output  1  high in READY and SEND.
REQ-012 SHALL have port: err  output  1  one-cycle pulse on a rejected din.

Function
REQ-013 SHALL implement states LOAD, CALC, READY, SEND.
REQ-014 LOAD SHALL accept din when din_valid=1 and din<=9: store it at index cnt (0..14), then cnt+1.
REQ-015 din>9 with din_valid=1 in LOAD SHALL be rejected: err=1 next cycle, cnt unchanged.
REQ-016 Running sum (8 bits) SHALL update on each accept: even cnt adds 2*din, minus 9 if >9; odd cnt adds din as-is.
REQ-017 Accepting the 15th digit (cnt=14) SHALL move LOAD->CALC; din_ready=0 from the next cycle.
REQ-018 CALC SHALL last exactly one cycle: check_digit = (10 - sum mod 10) mod 10; go to READY.
REQ-019 READY with run=1 SHALL go to SEND next cycle, with dout_active=1 and dout=check_digit in that same cycle.
REQ-020 run=1 in LOAD or CALC SHALL be ignored, with no effect on the load.
REQ-021 In SEND, out index starts at 15 (check digit); each dout_req=1 SHALL decrement it, and dout SHALL present the new digit the next cycle.
REQ-022 Out index k SHALL map to stored payload digit 14-k+... as follows: after the n-th dout_req (n=1..15), dout = payload[15-n].
REQ-023 dout_req after the 15th advance SHALL be ignored; dout holds payload[0].
REQ-024 dout_req outside SEND SHALL be ignored.
REQ-025 run=0 in SEND SHALL go to LOAD next cycle: cnt=0, sum=0, dout_active=0, check_valid=0.
REQ-026 dout SHALL be 0 whenever dout_active=0.
REQ-027 Max sum is 135; sum SHALL be 8 bits wide with no overflow handling.

Reset
REQ-028 reset=1 SHALL force, from any state including mid-SEND: state=LOAD, cnt=0, sum=0, out index=15, dout=0, dout_active=0, check_digit=0, check_valid=0, err=0, din_ready=1 next cycle.
REQ-029 Payload storage SHALL have no reset requirement; only values written in the current LOAD are observable.

Configuration
REQ-030 Macro LUHN_GEN_CORRUPT_EN defined: SHALL add input corrupt (1 bit); with corrupt=1 sampled in CALC, the emitted check digit SHALL be (correct+1) mod 10, so that the downstream checker reports invalid.
REQ-031 Macro LUHN_GEN_CORRUPT_EN undefined: the corrupt port and its logic SHALL be absent; behaviour as REQ-018.

Verification
REQ-032 Load 4,0x14 then run=1 -> check_digit=2; dout sequence 2, then fourteen 0s, then 4 over 15 dout_req pulses.
REQ-033 Load fifteen 9s -> check_digit=5 (sum 135); stream 5 followed by fifteen 9s.
REQ-034 din=12 with din_valid=1 at cnt=3 -> err pulse for 1 cycle, cnt stays 3, next valid digit lands at index 3.
REQ-035 Assert reset during SEND after 6 pulses -> next cycle dout_active=0, din_ready=1; reload of 15 zeros gives check_digit=0.
REQ-036 Connect to the existing Luhn checker, drive run=1 -> checker done=1 with validity=1; with LUHN_GEN_CORRUPT_EN and corrupt=1 -> validity=0.
REQ-037 run held high during load and extra dout_req after 15 pulses -> no early SEND; dout stays payload[0].
